window_line_buffer: RTL and testbench

Streaming sliding-window generator for the conv front-end. Accepts one pixel per handshake in raster order, with all NFMAPS channels in parallel. Holds KER_Y-1 previous image lines and emits a full KER_X x KER_Y window per channel, honouring independent X/Y strides. Image width and height are set at runtime, and valid/ready backpressure runs on both sides. Sits between the activation SRAM reader and the MAC array.

---
 rtl/cnn_buf_pkg.sv | 30 +++
 rtl/window_line_buffer_line_store.sv | 33 +++
 rtl/window_line_buffer.sv | 198 +++++++++++++++++++
 tb/tb_window_line_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared defaults, payload types and window layout helper for the conv front-end line buffer.
package cnn_buf_pkg;

    localparam int unsigned DEF_KER_X     = 3;
    localparam int unsigned DEF_KER_Y     = 3;
    localparam int unsigned DEF_STRIDE_X  = 1;
    localparam int unsigned DEF_STRIDE_Y  = 1;
    localparam int unsigned DEF_NBITS     = 8;
    localparam int unsigned DEF_NFMAPS    = 3;
    localparam int unsigned DEF_MAX_WIDTH = 64;

    localparam int unsigned WORD_W = DEF_NFMAPS * DEF_NBITS;
    localparam int unsigned WIN_W  = DEF_NFMAPS * DEF_KER_Y * DEF_KER_X * DEF_NBITS;

    typedef logic [WORD_W-1:0] pix_t;
    typedef pix_t win_t [DEF_KER_Y][DEF_KER_X];

    // Bit offset of element (channel f, window row r, window column c) in the flat window bus.
    function automatic int unsigned win_offset(
        input int unsigned f,
        input int unsigned r,
        input int unsigned c,
        input int unsigned ker_x,
        input int unsigned ker_y,
        input int unsigned nbits
    );
        return ((f * ker_y + r) * ker_x + c) * nbits;
    endfunction

endpackage

// File: rtl/window_line_buffer_line_store.sv
// Cascaded line memories: combinational read of every line at one column, then write-back
// shifts that column one line older and stores the new pixel in line 0.
module line_store #(
    parameter int unsigned NLINES = 2,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6,
    parameter int unsigned PIX_W  = 24
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [AW-1:0]                 addr_i,
    input  logic [PIX_W-1:0]              wdata_i,
    output logic [NLINES-1:0][PIX_W-1:0]  rdata_o
);

    logic [PIX_W-1:0] mem_q [NLINES][DEPTH];

    always_comb begin
        for (int unsigned k = 0; k < NLINES; k++) begin
            rdata_o[k] = mem_q[k][addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[0][addr_i] <= wdata_i;
            for (int unsigned k = 1; k < NLINES; k++) begin
                mem_q[k][addr_i] <= mem_q[k-1][addr_i];
            end
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// Streaming KER_X x KER_Y sliding-window generator with runtime image size, X/Y strides
// and valid/ready on both sides; one output register, one window per cycle at full rate.
module window_line_buffer
    import cnn_buf_pkg::*;
#(
    parameter int unsigned KER_X     = DEF_KER_X,
    parameter int unsigned KER_Y     = DEF_KER_Y,
    parameter int unsigned STRIDE_X  = DEF_STRIDE_X,
    parameter int unsigned STRIDE_Y  = DEF_STRIDE_Y,
    parameter int unsigned NBITS     = DEF_NBITS,
    parameter int unsigned NFMAPS    = DEF_NFMAPS,
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int unsigned CW        = $clog2(MAX_WIDTH + 1)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [CW-1:0]                       cfg_width,
    input  logic [CW-1:0]                       cfg_height,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NFMAPS*NBITS-1:0]             in_pix,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NFMAPS*KER_Y*KER_X*NBITS-1:0] out_win,
    output logic                                out_last,
    output logic                                cfg_err
);

    localparam int unsigned PIX_W  = NFMAPS * NBITS;
    localparam int unsigned NLINES = (KER_Y > 1) ? KER_Y - 1 : 1;
    localparam int unsigned AW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int unsigned SXW    = $clog2(STRIDE_X + 1);
    localparam int unsigned SYW    = $clog2(STRIDE_Y + 1);
    localparam int unsigned CW1    = CW + 1;

    logic [CW-1:0]  col_q, col_d, row_q, row_d;
    logic [CW-1:0]  width_q, width_d, height_q, height_d;
    logic [CW-1:0]  eff_w, eff_h;
    logic [SXW-1:0] sx_q, sx_d, sx_cur;
    logic [SYW-1:0] sy_q, sy_d, sy_cur;
    logic           out_valid_q, out_valid_d, out_last_q, out_last_d, cfg_err_q, cfg_err_d;
    logic           accept, frame_start, bad_cfg, col_end, row_end, emit;
    logic           last_row, last_col, line_we;

    logic [PIX_W-1:0]             win_q   [KER_Y][KER_X];
    logic [PIX_W-1:0]             win_d   [KER_Y][KER_X];
    logic [PIX_W-1:0]             new_col [KER_Y];
    logic [NLINES-1:0][PIX_W-1:0] line_rd;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;
    assign accept    = in_valid && in_ready;

    // Image size is taken straight from the inputs on the first pixel of a frame.
    assign frame_start = (col_q == '0) && (row_q == '0);
    assign eff_w       = frame_start ? cfg_width  : width_q;
    assign eff_h       = frame_start ? cfg_height : height_q;
    assign bad_cfg     = frame_start && ((cfg_width < CW'(KER_X)) ||
                                         (cfg_width > CW'(MAX_WIDTH)) ||
                                         (cfg_height < CW'(KER_Y)));
    assign col_end     = (col_q == eff_w - CW'(1));
    assign row_end     = (row_q == eff_h - CW'(1));

    assign sx_cur   = (col_q == CW'(KER_X - 1)) ? '0 : sx_q;
    assign sy_cur   = (row_q == CW'(KER_Y - 1)) ? '0 : sy_q;
    assign emit     = !cfg_err_q && !bad_cfg &&
                      (row_q >= CW'(KER_Y - 1)) && (col_q >= CW'(KER_X - 1)) &&
                      (sx_cur == '0) && (sy_cur == '0);
    // Last emitted position: one more stride step would fall off the image.
    assign last_row = ({1'b0, row_q} + CW1'(STRIDE_Y)) >= {1'b0, eff_h};
    assign last_col = ({1'b0, col_q} + CW1'(STRIDE_X)) >= {1'b0, eff_w};
    assign line_we  = accept && !flush && (col_q < CW'(MAX_WIDTH));

    if (KER_Y > 1) begin : g_lines
        line_store #(
            .NLINES (NLINES),
            .DEPTH  (MAX_WIDTH),
            .AW     (AW),
            .PIX_W  (PIX_W)
        ) u_line_store (
            .clk     (clk),
            .we_i    (line_we),
            .addr_i  (col_q[AW-1:0]),
            .wdata_i (in_pix),
            .rdata_o (line_rd)
        );
    end else begin : g_no_lines
        assign line_rd = '0;
    end

    // Incoming column: oldest line at r=0, the new pixel at the bottom.
    always_comb begin
        for (int unsigned r = 0; r < KER_Y; r++) begin
            new_col[r] = in_pix;
        end
        for (int unsigned k = 0; k + 1 < KER_Y; k++) begin
            new_col[KER_Y - 2 - k] = line_rd[k];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        width_d     = width_q;
        height_d    = height_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cfg_err_d   = cfg_err_q;
        win_d       = win_q;
        if (flush) begin
            col_d       = '0;
            row_d       = '0;
            sx_d        = '0;
            sy_d        = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept) begin
            if (frame_start) begin
                width_d  = cfg_width;
                height_d = cfg_height;
            end
            if (bad_cfg) begin
                cfg_err_d = 1'b1;
            end
            out_valid_d = emit;
            out_last_d  = emit && last_row && last_col;
            for (int unsigned r = 0; r < KER_Y; r++) begin
                for (int unsigned c = 0; c + 1 < KER_X; c++) begin
                    win_d[r][c] = win_q[r][c + 1];
                end
                win_d[r][KER_X - 1] = new_col[r];
            end
            sx_d = (sx_cur == SXW'(STRIDE_X - 1)) ? '0 : sx_cur + SXW'(1);
            if (col_end) begin
                col_d = '0;
                sx_d  = '0;
                sy_d  = (sy_cur == SYW'(STRIDE_Y - 1)) ? '0 : sy_cur + SYW'(1);
                if (row_end) begin
                    row_d = '0;
                    sy_d  = '0;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q       <= '0;
            row_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            width_q     <= '0;
            height_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int unsigned r = 0; r < KER_Y; r++) begin
                for (int unsigned c = 0; c < KER_X; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            width_q     <= width_d;
            height_q    <= height_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cfg_err_q   <= cfg_err_d;
            win_q       <= win_d;
        end
    end

    // The window register only moves on accepted pixels, so it doubles as the held output.
    for (genvar f = 0; f < NFMAPS; f++) begin : g_f
        for (genvar r = 0; r < KER_Y; r++) begin : g_r
            for (genvar c = 0; c < KER_X; c++) begin : g_c
                assign out_win[win_offset(f, r, c, KER_X, KER_Y, NBITS) +: NBITS] =
                    win_q[r][c][f*NBITS +: NBITS];
            end
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer: default 3x3/stride-1 instance plus a stride-2 instance.
module tb_window_line_buffer;
    import cnn_buf_pkg::*;

    localparam int CW = 7;
    localparam int KX = 3;
    localparam int KY = 3;
    localparam int NB = 8;
    localparam int NF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [CW-1:0]   cfg_width, cfg_height;
    logic            flush, in_valid, out_ready, sel;
    pix_t            in_pix;
    logic            in_valid0, in_valid1, in_ready0, in_ready1;
    logic            out_valid0, out_valid1, out_last0, out_last1, cfg_err0, cfg_err1;
    logic [WIN_W-1:0] out_win0, out_win1;

    assign in_valid0 = in_valid && !sel;
    assign in_valid1 = in_valid && sel;

    window_line_buffer dut (
        .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0), .in_pix(in_pix),
        .out_valid(out_valid0), .out_ready(out_ready), .out_win(out_win0),
        .out_last(out_last0), .cfg_err(cfg_err0)
    );

    window_line_buffer #(.STRIDE_X(2), .STRIDE_Y(2)) dut_s (
        .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1), .in_pix(in_pix),
        .out_valid(out_valid1), .out_ready(out_ready), .out_win(out_win1),
        .out_last(out_last1), .cfg_err(cfg_err1)
    );

    typedef struct {
        logic [WIN_W-1:0] win;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0, n_fail = 0, n_acc = 0, n_out = 0, n_last = 0;
    int               mr = 0, mc = 0, mw = 0, mh = 0;
    bit               m_err = 1'b0;
    bit               want_first = 1'b0;
    logic [WIN_W-1:0] first_win;

    function automatic logic [7:0] pv(input int r, input int c, input int f);
        return 8'((r * 16 + c) ^ (f * 64));
    endfunction

    function automatic pix_t mkpix(input int r, input int c);
        pix_t p;
        for (int f = 0; f < NF; f++) p[f*NB +: NB] = pv(r, c, f);
        return p;
    endfunction

    // Reference model: advance one accepted pixel, queue the window it completes.
    task automatic model_accept();
        int   sx, sy, lr, lc;
        exp_t e;
        sx = sel ? 2 : 1;
        sy = sel ? 2 : 1;
        if (mr == 0 && mc == 0) begin
            mw = int'(cfg_width);
            mh = int'(cfg_height);
            if (mw < KX || mw > 64 || mh < KY) m_err = 1'b1;
        end
        if (!m_err && mr >= KY-1 && mc >= KX-1 &&
            (mr-(KY-1)) % sy == 0 && (mc-(KX-1)) % sx == 0) begin
            lr = (KY-1) + ((mh-KY) / sy) * sy;
            lc = (KX-1) + ((mw-KX) / sx) * sx;
            e.win = '0;
            for (int f = 0; f < NF; f++)
                for (int r = 0; r < KY; r++)
                    for (int c = 0; c < KX; c++)
                        e.win[((f*KY + r)*KX + c)*NB +: NB] = pv(mr-KY+1+r, mc-KX+1+c, f);
            e.last = (mr == lr) && (mc == lc);
            sb.push_back(e);
        end
        mc++;
        if (mc >= mw) begin
            mc = 0;
            mr++;
            if (mr >= mh) mr = 0;
        end
    endtask

    // One clock: sample at negedge, score any output handshake, model any input handshake.
    task automatic tick();
        logic             ov, lst, ir;
        logic [WIN_W-1:0] w;
        exp_t             e;
        @(negedge clk);
        ov  = sel ? out_valid1 : out_valid0;
        lst = sel ? out_last1  : out_last0;
        ir  = sel ? in_ready1  : in_ready0;
        w   = sel ? out_win1   : out_win0;
        if (ov && out_ready) begin
            n_out++;
            if (lst) n_last++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_window: got %h, required none", w);
            end else begin
                e = sb.pop_front();
                if (want_first) begin
                    first_win  = w;
                    want_first = 1'b0;
                end
                n_cmp++;
                if (w !== e.win) begin
                    n_fail++;
                    $display("FAIL window_data: got %h required %h", w, e.win);
                end
                n_cmp++;
                if (lst !== e.last) begin
                    n_fail++;
                    $display("FAIL window_last: got %0b required %0b", lst, e.last);
                end
            end
        end
        if (flush) begin
            mr = 0;
            mc = 0;
            sb.delete();
        end else if (in_valid && ir) begin
            n_acc++;
            model_accept();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input int n, input bit rnd_ready);
        int target, budget;
        target = n_acc + n;
        budget = 0;
        while (n_acc < target && budget < 4000) begin
            in_valid = 1'b1;
            in_pix   = mkpix(mr, mc);
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc != target) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d required %0d", n_acc - target + n, n);
        end
    endtask

    task automatic drain();
        int budget;
        budget    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((sb.size() != 0 || (sel ? out_valid1 : out_valid0)) && budget < 100) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d windows still pending, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rstn      = 1'b0;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        mr    = 0;
        mc    = 0;
        mw    = 0;
        mh    = 0;
        m_err = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int got_w, input int req_w,
                                input int got_l, input int req_l);
        n_cmp++;
        if (got_w != req_w) begin
            n_fail++;
            $display("FAIL %s_windows: got %0d required %0d", name, got_w, req_w);
        end
        n_cmp++;
        if (got_l != req_l) begin
            n_fail++;
            $display("FAIL %s_lasts: got %0d required %0d", name, got_l, req_l);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sel = 1'b0;
        cfg_width = 7'd5; cfg_height = 7'd4; in_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid0); end
        n_cmp++; if (out_last0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last0); end
        n_cmp++; if (out_win0 !== '0) begin n_fail++; $display("FAIL reset_out_win: got %h required 0", out_win0); end
        n_cmp++; if (cfg_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b required 0", cfg_err0); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready0); end
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_stride_out_valid: got %b required 0", out_valid1); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int bo, bl;
        do_reset();
        sel = 1'b0; cfg_width = 7'd5; cfg_height = 7'd4;
        bo = n_out; bl = n_last; want_first = 1'b1;
        send_pixels(20, 1'b0);
        drain();
        check_counts("directed", n_out - bo, 6, n_last - bl, 1);
        n_cmp++; if (first_win[7:0]   !== 8'h00) begin n_fail++; $display("FAIL first_r0c0: got %h required 00", first_win[7:0]); end
        n_cmp++; if (first_win[23:16] !== 8'h02) begin n_fail++; $display("FAIL first_r0c2: got %h required 02", first_win[23:16]); end
        n_cmp++; if (first_win[55:48] !== 8'h20) begin n_fail++; $display("FAIL first_r2c0: got %h required 20", first_win[55:48]); end
        n_cmp++; if (first_win[71:64] !== 8'h22) begin n_fail++; $display("FAIL first_r2c2: got %h required 22", first_win[71:64]); end
        n_cmp++; if (first_win[143:136] !== 8'h62) begin n_fail++; $display("FAIL first_f1r2c2: got %h required 62", first_win[143:136]); end
    endtask

    task automatic test_stride();
        int bo, bl;
        do_reset();
        sel = 1'b1; cfg_width = 7'd7; cfg_height = 7'd7;
        bo = n_out; bl = n_last;
        send_pixels(49, 1'b0);
        drain();
        check_counts("stride", n_out - bo, 9, n_last - bl, 1);
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int bo, bl, ba, budget;
        logic [WIN_W-1:0] hold;
        do_reset();
        sel = 1'b0; cfg_width = 7'd5; cfg_height = 7'd4;
        bo = n_out; bl = n_last; ba = n_acc; budget = 0;
        while (!out_valid0 && budget < 100) begin
            in_valid = 1'b1;
            in_pix   = mkpix(mr, mc);
            tick();
            budget++;
        end
        n_cmp++;
        if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL bp_first_window: got %b required 1", out_valid0); end
        out_ready = 1'b0;
        hold      = out_win0;
        for (int i = 0; i < 5; i++) begin
            in_pix = mkpix(mr, mc);
            tick();
            n_cmp++; if (out_win0 !== hold) begin n_fail++; $display("FAIL bp_hold_win: got %h required %h", out_win0, hold); end
            n_cmp++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready0); end
            n_cmp++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b required 1", out_valid0); end
        end
        out_ready = 1'b1;
        send_pixels(20 - (n_acc - ba), 1'b0);
        drain();
        check_counts("backpressure", n_out - bo, 6, n_last - bl, 1);
    endtask

    task automatic test_flush();
        int bo, bl;
        do_reset();
        sel = 1'b0; cfg_width = 7'd5; cfg_height = 7'd4;
        send_pixels(11, 1'b0);
        in_valid = 1'b1;
        in_pix   = mkpix(mr, mc);
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b required 0", out_valid0); end
        bo = n_out; bl = n_last;
        send_pixels(20, 1'b0);
        drain();
        check_counts("flush", n_out - bo, 6, n_last - bl, 1);
    endtask

    task automatic test_cfg_err();
        int bo, ba;
        do_reset();
        sel = 1'b0; cfg_width = 7'd2; cfg_height = 7'd4;
        bo = n_out; ba = n_acc;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_pix   = mkpix(mr, mc);
            tick();
            n_cmp++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL cfgerr_out_valid: got %b required 0", out_valid0); end
            n_cmp++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL cfgerr_in_ready: got %b required 1", in_ready0); end
        end
        in_valid = 1'b0;
        check_counts("cfgerr", n_acc - ba, 16, n_out - bo, 0);
        n_cmp++; if (cfg_err0 !== 1'b1) begin n_fail++; $display("FAIL cfgerr_flag: got %b required 1", cfg_err0); end
        do_reset();
        n_cmp++; if (cfg_err0 !== 1'b0) begin n_fail++; $display("FAIL cfgerr_clear: got %b required 0", cfg_err0); end
    endtask

    task automatic test_back_to_back();
        int bo, bl;
        do_reset();
        sel = 1'b0; cfg_width = 7'd5; cfg_height = 7'd4;
        bo = n_out; bl = n_last;
        send_pixels(3, 1'b0);
        cfg_width = 7'd6;
        send_pixels(17, 1'b0);
        send_pixels(24, 1'b1);
        drain();
        check_counts("back_to_back", n_out - bo, 14, n_last - bl, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_stride();
        test_backpressure();
        test_flush();
        test_cfg_err();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
